bin_div: RTL

Iterative unsigned restoring divider that reverses `bin_mult`. It takes a 2·WIDTH-bit dividend, such as a product, and a WIDTH-bit divisor, and returns a WIDTH-bit quotient and a WIDTH-bit remainder. It sits beside `bin_mult` in the arithmetic datapath, so `bin_mult` results can be divided back down and cross-checked. It retires one quotient bit per clock, uses a start/busy/done handshake, and flags divide-by-zero and quotient overflow.

---
 rtl/bin_div.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/bin_div.sv
// ---------------------------------------------------------------------------
// bin_div -- iterative unsigned restoring divider.
//
// Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor and produces a
// WIDTH-bit quotient and remainder. It retires one quotient bit per clock.
// The usual source of the dividend is a bin_mult product.
//
// Ports
//   CLK          clock, rising edge
//   rst          synchronous active-high reset
//   start        request a division (accepted in IDLE or DONE)
//   N            dividend (2*WIDTH), captured on the accepting edge
//   D            divisor (WIDTH), captured on the accepting edge
//   busy         division in progress
//   done         one-cycle pulse; Q/R/flags valid from this cycle on
//   Q, R         quotient / remainder, held until the next division
//   div_by_zero  captured divisor was zero
//   overflow     quotient would not fit in WIDTH bits
//   fsm_state    current controller state, for observation only
//
// Handshake: start is sampled on a rising edge only while the controller is
// not busy (IDLE or DONE). That edge captures N/D and is the accepting edge.
// busy stays high until the result is ready. done then pulses for exactly
// one cycle. A start seen during the done cycle begins the next division
// with no idle bubble.
// ---------------------------------------------------------------------------
module bin_div #(
    parameter int WIDTH = 32
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] N,
    input  logic [WIDTH-1:0]   D,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   Q,
    output logic [WIDTH-1:0]   R,
    output logic               div_by_zero,
    output logic               overflow,
    output logic [1:0]         fsm_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] rem;      // partial remainder, always < divisor once legal
    logic [WIDTH-1:0] dvd;      // remaining dividend bits, MSB first
    logic [WIDTH-1:0] dsr;      // captured divisor
    logic [CW-1:0]    cnt;      // iterations completed
    logic             accept;
    logic             first_iter;
    logic             illegal;
    logic             last_iter;
    logic [WIDTH:0]   trial;
    logic             trial_ge;
    logic [WIDTH-1:0] rem_nxt;

    assign fsm_state = state;

    // On the first CALC cycle, rem still holds the dividend high half.
    // The operands are illegal when that high half is >= the divisor,
    // or when the divisor is zero.
    // Checking the registered operands here gives illegal operands their
    // single busy cycle before done.
    assign first_iter = (cnt == '0);
    assign illegal    = first_iter && ((dsr == '0) || (rem >= dsr));
    assign last_iter  = (cnt == CW'(WIDTH - 1));

    // One restoring step. rem < dsr holds here, so the trial value fits in
    // WIDTH+1 bits. After a successful subtract the result is < dsr, so the
    // low WIDTH bits of the difference are enough.
    assign trial    = {rem, dvd[WIDTH-1]};
    assign trial_ge = (trial >= {1'b0, dsr});
    assign rem_nxt  = trial_ge ? (trial[WIDTH-1:0] - dsr) : trial[WIDTH-1:0];

    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (illegal || last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            rem         <= '0;
            dvd         <= '0;
            dsr         <= '0;
            cnt         <= '0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept) begin
            rem         <= N[2*WIDTH-1:WIDTH];
            dvd         <= N[WIDTH-1:0];
            dsr         <= D;
            cnt         <= '0;
            Q           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (state == CALC) begin
            if (illegal) begin
                Q           <= '1;
                R           <= '0;
                div_by_zero <= (dsr == '0);
                overflow    <= (dsr != '0);
            end else begin
                rem <= rem_nxt;
                dvd <= {dvd[WIDTH-2:0], 1'b0};
                Q   <= {Q[WIDTH-2:0], trial_ge};
                cnt <= cnt + CW'(1);
                if (last_iter) begin
                    R <= rem_nxt;
                end
            end
        end
    end

endmodule
